// File: rtl/lif_pkg.sv
// Shared constants for the LIF neuron array.
// Latency: n/a (package only).
// Backpressure: n/a (package only).
package lif_pkg;

  // Post-spike membrane behaviour selectors.
  localparam int RESET_ZERO     = 0;
  localparam int RESET_SUBTRACT = 1;

  // Width of the global spike counter.
  localparam int SPIKE_CNT_W = 16;

  // Firing threshold used when the integrator has no better value.
  localparam int DEFAULT_THRESHOLD = 200;

  // Width needed to hold a refractory countdown of 0..refrac.
  // A disabled refractory period still keeps a 1-bit counter that stays at 0.
  function automatic int refrac_cnt_w(input int refrac);
    return (refrac < 1) ? 1 : $clog2(refrac + 1);
  endfunction

endpackage

// File: rtl/lif_update_core.sv
// Combinational single-neuron LIF update: leak, saturating add, compare, reset, refractory.
// Latency: 0 cycles (pure combinational).
// Backpressure: none; the caller decides when the result is committed.
//
// Ports:
//   state / refrac         current membrane value and refractory countdown
//   current / threshold    input current and firing threshold (0 disables firing)
//   next_state / next_refrac / spike   values to commit for this update
module lif_update_core
  import lif_pkg::*;
#(
  parameter int WIDTH          = 8,
  parameter int LEAK_SHIFT     = 1,
  parameter int REFRAC_UPDATES = 2,
  parameter int RESET_MODE     = RESET_ZERO,
  parameter int CNT_W          = 2
) (
  input  logic [WIDTH-1:0] state,
  input  logic [CNT_W-1:0] refrac,
  input  logic [WIDTH-1:0] current,
  input  logic [WIDTH-1:0] threshold,
  output logic [WIDTH-1:0] next_state,
  output logic [CNT_W-1:0] next_refrac,
  output logic             spike
);

  localparam logic [CNT_W-1:0] REFRAC_LOAD = CNT_W'(REFRAC_UPDATES);

  logic [WIDTH-1:0] leaked;
  logic [WIDTH:0]   sum_wide;
  logic [WIDTH-1:0] sum_sat;

  // Leak removes a fraction of the state; this never underflows.
  assign leaked   = state - (state >> LEAK_SHIFT);
  // One extra bit catches the carry so the sum can clip at full scale.
  assign sum_wide = {1'b0, leaked} + {1'b0, current};
  assign sum_sat  = sum_wide[WIDTH] ? '1 : sum_wide[WIDTH-1:0];

  always_comb begin
    next_state  = sum_sat;
    next_refrac = '0;
    spike       = 1'b0;
    if (|refrac) begin
      // Refractory: the input current is ignored but leak still applies.
      next_state  = leaked;
      next_refrac = refrac - CNT_W'(1);
    end else if ((|threshold) && (sum_sat >= threshold)) begin
      spike       = 1'b1;
      next_refrac = REFRAC_LOAD;
      next_state  = (RESET_MODE == RESET_SUBTRACT) ? (sum_sat - threshold) : '0;
    end
  end

endmodule

// File: rtl/lif_neuron_array.sv
// Time-multiplexed array of LIF neurons sharing one update datapath, plus a global spike counter.
// Latency: 1 cycle from accept to registered result; state memory written on the same edge.
// Backpressure: in_ready = !out_valid || out_ready; the result register holds while stalled.
//
// Ports:
//   clk, reset_n                       clock and async active-low reset
//   threshold                          firing threshold sampled at accept (0 = no firing)
//   in_valid/in_ready/in_idx/in_current         input transaction
//   out_valid/out_ready/out_idx/out_spike/out_state   registered update result
//   spike_count                        saturating count of spikes since reset
module lif_neuron_array
  import lif_pkg::*;
#(
  parameter int WIDTH          = 8,
  parameter int NUM_NEURONS    = 4,
  parameter int LEAK_SHIFT     = 1,
  parameter int REFRAC_UPDATES = 2,
  parameter int RESET_MODE     = RESET_ZERO,
  parameter int IDX_W          = $clog2(NUM_NEURONS)
) (
  input  logic                   clk,
  input  logic                   reset_n,
  input  logic [WIDTH-1:0]       threshold,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [IDX_W-1:0]       in_idx,
  input  logic [WIDTH-1:0]       in_current,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [IDX_W-1:0]       out_idx,
  output logic                   out_spike,
  output logic [WIDTH-1:0]       out_state,
  output logic [SPIKE_CNT_W-1:0] spike_count
);

  localparam int               CNT_W        = refrac_cnt_w(REFRAC_UPDATES);
  localparam logic [IDX_W:0]   NEURON_LIMIT = (IDX_W + 1)'(NUM_NEURONS);

  logic [WIDTH-1:0] state_mem  [NUM_NEURONS];
  logic [CNT_W-1:0] refrac_mem [NUM_NEURONS];

  logic             accept;
  logic             idx_ok;
  logic [WIDTH-1:0] rd_state;
  logic [CNT_W-1:0] rd_refrac;
  logic [WIDTH-1:0] nxt_state;
  logic [CNT_W-1:0] nxt_refrac;
  logic             nxt_spike;

  assign in_ready = !out_valid || out_ready;
  assign accept   = in_valid && in_ready;
  // Indices past the last neuron only exist for non-power-of-two counts;
  // such transactions are consumed and dropped.
  assign idx_ok    = {1'b0, in_idx} < NEURON_LIMIT;
  assign rd_state  = idx_ok ? state_mem[in_idx]  : '0;
  assign rd_refrac = idx_ok ? refrac_mem[in_idx] : '0;

  lif_update_core #(
    .WIDTH          (WIDTH),
    .LEAK_SHIFT     (LEAK_SHIFT),
    .REFRAC_UPDATES (REFRAC_UPDATES),
    .RESET_MODE     (RESET_MODE),
    .CNT_W          (CNT_W)
  ) u_core (
    .state       (rd_state),
    .refrac      (rd_refrac),
    .current     (in_current),
    .threshold   (threshold),
    .next_state  (nxt_state),
    .next_refrac (nxt_refrac),
    .spike       (nxt_spike)
  );

  // Memory write and output register share one edge, so a back-to-back
  // update of the same neuron reads the value written by the previous one.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < NUM_NEURONS; i++) begin
        state_mem[i]  <= '0;
        refrac_mem[i] <= '0;
      end
      out_valid   <= 1'b0;
      out_idx     <= '0;
      out_spike   <= 1'b0;
      out_state   <= '0;
      spike_count <= '0;
    end else begin
      if (accept && idx_ok) begin
        state_mem[in_idx]  <= nxt_state;
        refrac_mem[in_idx] <= nxt_refrac;
        out_valid          <= 1'b1;
        out_idx            <= in_idx;
        out_spike          <= nxt_spike;
        out_state          <= nxt_state;
        if (nxt_spike && (spike_count != '1)) begin
          spike_count <= spike_count + SPIKE_CNT_W'(1);
        end
      end else if (out_ready) begin
        // Handshake completes (or a dropped index was consumed): result retires.
        out_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_lif_neuron_array.sv
// Bench for lif_neuron_array: three instances (zero-reset, subtract-reset, 3-neuron)
// driven in lockstep and compared against an arithmetic reference model.
module tb_lif_neuron_array;

  logic       clk = 1'b0;
  logic       reset_n = 1'b0;
  logic [7:0] threshold = 8'd0;
  logic       in_valid = 1'b0;
  logic [1:0] in_idx = 2'd0;
  logic [7:0] in_current = 8'd0;
  logic       out_ready = 1'b1;

  logic        rdy   [3];
  logic        o_vld [3];
  logic [1:0]  o_idx [3];
  logic        o_spike [3];
  logic [7:0]  o_state [3];
  logic [15:0] o_cnt [3];

  int n_checks = 0;
  int n_err    = 0;

  always #5 clk = ~clk;

  lif_neuron_array #(.WIDTH(8), .NUM_NEURONS(4), .LEAK_SHIFT(1), .REFRAC_UPDATES(2), .RESET_MODE(0)) dut0 (
    .clk(clk), .reset_n(reset_n), .threshold(threshold), .in_valid(in_valid), .in_ready(rdy[0]),
    .in_idx(in_idx), .in_current(in_current), .out_valid(o_vld[0]), .out_ready(out_ready),
    .out_idx(o_idx[0]), .out_spike(o_spike[0]), .out_state(o_state[0]), .spike_count(o_cnt[0]));

  lif_neuron_array #(.WIDTH(8), .NUM_NEURONS(4), .LEAK_SHIFT(1), .REFRAC_UPDATES(2), .RESET_MODE(1)) dut1 (
    .clk(clk), .reset_n(reset_n), .threshold(threshold), .in_valid(in_valid), .in_ready(rdy[1]),
    .in_idx(in_idx), .in_current(in_current), .out_valid(o_vld[1]), .out_ready(out_ready),
    .out_idx(o_idx[1]), .out_spike(o_spike[1]), .out_state(o_state[1]), .spike_count(o_cnt[1]));

  lif_neuron_array #(.WIDTH(8), .NUM_NEURONS(3), .LEAK_SHIFT(1), .REFRAC_UPDATES(2), .RESET_MODE(0)) dut2 (
    .clk(clk), .reset_n(reset_n), .threshold(threshold), .in_valid(in_valid), .in_ready(rdy[2]),
    .in_idx(in_idx), .in_current(in_current), .out_valid(o_vld[2]), .out_ready(out_ready),
    .out_idx(o_idx[2]), .out_spike(o_spike[2]), .out_state(o_state[2]), .spike_count(o_cnt[2]));

  // ---------------- reference model ----------------
  int nn   [3] = '{4, 4, 3};
  int mode [3] = '{0, 1, 0};
  int m_state [3][4];
  int m_cnt   [3][4];
  int m_count [3];
  logic       e_vld [3];
  logic [1:0] e_idx [3];
  logic [7:0] e_state [3];
  logic       e_spike [3];

  function automatic void model_reset();
    for (int m = 0; m < 3; m++) begin
      for (int i = 0; i < 4; i++) begin
        m_state[m][i] = 0;
        m_cnt[m][i]   = 0;
      end
      m_count[m] = 0;
      e_vld[m] = 1'b0; e_idx[m] = 2'd0; e_state[m] = 8'd0; e_spike[m] = 1'b0;
    end
  endfunction

  // One accepted transaction as seen by each neuron array.
  function automatic void model_accept(int idx, int cur, int thr);
    for (int m = 0; m < 3; m++) begin
      if (idx >= nn[m]) begin
        e_vld[m] = 1'b0;
      end else begin
        int s, leaked, sum, ns;
        bit spk;
        s = m_state[m][idx];
        leaked = s - s / 2;
        spk = 0;
        if (m_cnt[m][idx] > 0) begin
          ns = leaked;
          m_cnt[m][idx] = m_cnt[m][idx] - 1;
        end else begin
          sum = leaked + cur;
          if (sum > 255) sum = 255;
          spk = (thr != 0) && (sum >= thr);
          if (spk) begin
            ns = (mode[m] == 1) ? sum - thr : 0;
            m_cnt[m][idx] = 2;
            if (m_count[m] < 65535) m_count[m] = m_count[m] + 1;
          end else begin
            ns = sum;
          end
        end
        m_state[m][idx] = ns;
        e_vld[m] = 1'b1; e_idx[m] = 2'(idx); e_state[m] = 8'(ns); e_spike[m] = spk;
      end
    end
  endfunction

  function automatic logic [27:0] exp_vec(int m);
    return {e_vld[m], e_idx[m], e_state[m], e_spike[m], 16'(m_count[m])};
  endfunction

  function automatic logic [27:0] got_vec(int m);
    return {o_vld[m], o_idx[m], o_state[m], o_spike[m], o_cnt[m]};
  endfunction

  // Present one transaction (out_ready assumed high) and advance the model.
  task automatic drive(int idx, int cur, int thr);
    @(negedge clk);
    in_valid = 1'b1; in_idx = 2'(idx); in_current = 8'(cur); threshold = 8'(thr);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    model_accept(idx, cur, thr);
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset_n = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset_n = 1'b1;
    model_reset();
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    out_ready = 1'b1;
    do_reset();
    #1;
    for (int m = 0; m < 3; m++) begin
      n_checks++;
      if (got_vec(m) !== 28'd0) begin
        n_err++;
        $display("FAIL reset_outputs dut%0d got=%h exp=%h", m, got_vec(m), 28'd0);
      end
      n_checks++;
      if (rdy[m] !== 1'b1) begin
        n_err++;
        $display("FAIL reset_in_ready dut%0d got=%b exp=1", m, rdy[m]);
      end
    end
  endtask

  task automatic test_integrate_fire();
    drive(0, 150, 200);
    n_checks++;
    if (o_state[0] !== 8'd150 || o_spike[0] !== 1'b0) begin
      n_err++;
      $display("FAIL integ_first got state=%0d spike=%b exp state=150 spike=0", o_state[0], o_spike[0]);
    end
    for (int m = 0; m < 3; m++) begin
      n_checks++;
      if (got_vec(m) !== exp_vec(m)) begin
        n_err++;
        $display("FAIL integ_first_model dut%0d got=%h exp=%h", m, got_vec(m), exp_vec(m));
      end
    end
    drive(0, 150, 200);
    n_checks++;
    if (o_state[0] !== 8'd0 || o_spike[0] !== 1'b1 || o_cnt[0] !== 16'd1) begin
      n_err++;
      $display("FAIL integ_fire got state=%0d spike=%b cnt=%0d exp state=0 spike=1 cnt=1",
               o_state[0], o_spike[0], o_cnt[0]);
    end
    n_checks++;
    if (o_state[1] !== 8'd25 || o_spike[1] !== 1'b1) begin
      n_err++;
      $display("FAIL integ_fire_subtract got state=%0d spike=%b exp state=25 spike=1", o_state[1], o_spike[1]);
    end
    for (int m = 0; m < 3; m++) begin
      n_checks++;
      if (got_vec(m) !== exp_vec(m)) begin
        n_err++;
        $display("FAIL integ_fire_model dut%0d got=%h exp=%h", m, got_vec(m), exp_vec(m));
      end
    end
  endtask

  task automatic test_refractory();
    logic [7:0] want [3];
    want[0] = 8'd0; want[1] = 8'd0; want[2] = 8'd150;
    for (int k = 0; k < 3; k++) begin
      drive(0, 150, 200);
      n_checks++;
      if (o_state[0] !== want[k] || o_spike[0] !== 1'b0) begin
        n_err++;
        $display("FAIL refrac_step%0d got state=%0d spike=%b exp state=%0d spike=0", k, o_state[0], o_spike[0], want[k]);
      end
      for (int m = 0; m < 3; m++) begin
        n_checks++;
        if (got_vec(m) !== exp_vec(m)) begin
          n_err++;
          $display("FAIL refrac_model%0d dut%0d got=%h exp=%h", k, m, got_vec(m), exp_vec(m));
        end
      end
    end
  endtask

  task automatic test_saturation();
    for (int k = 0; k < 2; k++) begin
      drive(1, 255, 0);
      n_checks++;
      if (o_state[0] !== 8'd255 || o_spike[0] !== 1'b0 || o_cnt[0] !== 16'd1) begin
        n_err++;
        $display("FAIL saturate%0d got state=%0d spike=%b cnt=%0d exp state=255 spike=0 cnt=1",
                 k, o_state[0], o_spike[0], o_cnt[0]);
      end
      for (int m = 0; m < 3; m++) begin
        n_checks++;
        if (got_vec(m) !== exp_vec(m)) begin
          n_err++;
          $display("FAIL saturate_model%0d dut%0d got=%h exp=%h", k, m, got_vec(m), exp_vec(m));
        end
      end
    end
  endtask

  task automatic test_backpressure();
    logic [27:0] held [3];
    drive(2, 40, 200);
    for (int m = 0; m < 3; m++) held[m] = got_vec(m);
    @(negedge clk);
    out_ready = 1'b0;
    // A pending input must not be taken while the result is stalled.
    in_valid = 1'b1; in_idx = 2'd0; in_current = 8'd77; threshold = 8'd200;
    for (int c = 0; c < 5; c++) begin
      @(posedge clk);
      #1;
      for (int m = 0; m < 3; m++) begin
        n_checks++;
        if (rdy[m] !== 1'b0 || got_vec(m) !== exp_vec(m) || got_vec(m) !== held[m]) begin
          n_err++;
          $display("FAIL stall_c%0d dut%0d in_ready=%b got=%h exp=%h", c, m, rdy[m], got_vec(m), exp_vec(m));
        end
      end
    end
    @(negedge clk);
    out_ready = 1'b1;
    #1;
    for (int m = 0; m < 3; m++) begin
      n_checks++;
      if (rdy[m] !== 1'b1) begin
        n_err++;
        $display("FAIL release_ready dut%0d got=%b exp=1", m, rdy[m]);
      end
    end
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    model_accept(0, 77, 200);
    for (int m = 0; m < 3; m++) begin
      n_checks++;
      if (got_vec(m) !== exp_vec(m)) begin
        n_err++;
        $display("FAIL release_accept dut%0d got=%h exp=%h", m, got_vec(m), exp_vec(m));
      end
    end
  endtask

  task automatic test_independence_reset();
    int idxs [4] = '{0, 1, 0, 1};
    int curs [4] = '{100, 50, 100, 50};
    logic [7:0] want [4];
    want[0] = 8'd100; want[1] = 8'd50; want[2] = 8'd150; want[3] = 8'd75;
    do_reset();
    for (int k = 0; k < 4; k++) begin
      drive(idxs[k], curs[k], 200);
      n_checks++;
      if (o_state[0] !== want[k] || o_idx[0] !== 2'(idxs[k])) begin
        n_err++;
        $display("FAIL indep%0d got idx=%0d state=%0d exp idx=%0d state=%0d", k, o_idx[0], o_state[0], idxs[k], want[k]);
      end
    end
    drive(2, 20, 200);
    @(negedge clk);
    out_ready = 1'b0;
    #2;
    reset_n = 1'b0;
    #1;
    for (int m = 0; m < 3; m++) begin
      n_checks++;
      if (o_vld[m] !== 1'b0 || rdy[m] !== 1'b1) begin
        n_err++;
        $display("FAIL midreset dut%0d out_valid=%b in_ready=%b exp out_valid=0 in_ready=1", m, o_vld[m], rdy[m]);
      end
    end
    @(negedge clk);
    reset_n = 1'b1;
    out_ready = 1'b1;
    model_reset();
    for (int i = 0; i < 4; i++) begin
      drive(i, 0, 200);
      n_checks++;
      if (o_state[0] !== 8'd0 || o_cnt[0] !== 16'd0) begin
        n_err++;
        $display("FAIL readback%0d got state=%0d cnt=%0d exp state=0 cnt=0", i, o_state[0], o_cnt[0]);
      end
      for (int m = 0; m < 3; m++) begin
        n_checks++;
        if (got_vec(m) !== exp_vec(m)) begin
          n_err++;
          $display("FAIL readback_model%0d dut%0d got=%h exp=%h", i, m, got_vec(m), exp_vec(m));
        end
      end
    end
  endtask

  task automatic test_out_of_range();
    drive(2, 30, 200);
    drive(3, 50, 200);
    n_checks++;
    if (o_vld[2] !== 1'b0 || o_vld[0] !== 1'b1) begin
      n_err++;
      $display("FAIL oob_drop got vld3n=%b vld4n=%b exp vld3n=0 vld4n=1", o_vld[2], o_vld[0]);
    end
    drive(2, 0, 200);
    for (int m = 0; m < 3; m++) begin
      n_checks++;
      if (got_vec(m) !== exp_vec(m)) begin
        n_err++;
        $display("FAIL oob_after dut%0d got=%h exp=%h", m, got_vec(m), exp_vec(m));
      end
    end
  endtask

  task automatic test_random();
    for (int t = 0; t < 300; t++) begin
      int idx, cur, thr, sel;
      idx = int'($urandom_range(0, 3));
      cur = int'($urandom_range(0, 255));
      sel = int'($urandom_range(0, 3));
      thr = (sel == 0) ? 0 : (sel == 1) ? 200 : int'($urandom_range(1, 255));
      drive(idx, cur, thr);
      for (int m = 0; m < 3; m++) begin
        n_checks++;
        if (got_vec(m) !== exp_vec(m)) begin
          n_err++;
          $display("FAIL random t=%0d dut%0d idx=%0d cur=%0d thr=%0d got=%h exp=%h",
                   t, m, idx, cur, thr, got_vec(m), exp_vec(m));
        end
      end
    end
  endtask

  initial begin
    model_reset();
    test_reset();
    test_integrate_fire();
    test_refractory();
    test_saturation();
    test_backpressure();
    test_independence_reset();
    test_out_of_range();
    test_random();
    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
